// File: rtl/down_counter_fsm.sv
// ---------------------------------------------------------------------------
// down_counter_fsm
//   Loadable down-counter with a start/busy/done handshake. A run loads
//   load_val and counts down to zero; reaching zero is a terminal event that
//   pulses done and either stops (back to IDLE) or reloads the start value
//   and keeps running when reload_en is high. tc_count counts terminal
//   events since the last accepted start and saturates at all-ones.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   load_val   in   WIDTH  start value, sampled when start is accepted
//   start      in   1      begin a run (accepted only in IDLE)
//   pause      in   1      hold the count while running
//   abort      in   1      end the run immediately, no done pulse
//   reload_en  in   1      at terminal: 1 = reload and continue, 0 = stop
//   count      out  WIDTH  remaining count
//   busy       out  1      high while running
//   done       out  1      one-cycle pulse per terminal event
//   tc_count   out  TC_W   terminal events since last start, saturating
// ---------------------------------------------------------------------------
module down_counter_fsm #(
  parameter int WIDTH = 16,
  parameter int TC_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             reload_en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [TC_W-1:0]  tc_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [TC_W-1:0]  tc_q,     tc_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = tc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort outranks start: an aborted start leaves everything untouched
        if (!abort && start) begin
          count_d  = load_val;
          reload_d = load_val;
          tc_d     = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        if (abort) begin
          count_d = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (pause) begin
          // hold everything, including at count==0 (terminal deferred)
          count_d = count_q;
        end else if (count_q == '0) begin
          done_d = 1'b1;
          tc_d   = (tc_q == {TC_W{1'b1}}) ? tc_q : tc_q + 1'b1;
          if (reload_en) begin
            count_d = reload_q;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count    = count_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tc_count = tc_q;

endmodule

// File: tb/tb_down_counter_fsm.sv
// ---------------------------------------------------------------------------
// tb_down_counter_fsm
//   Directed bench for down_counter_fsm. A table of per-cycle input/expected
//   output records drives the main instance (WIDTH=16, TC_W=8); hand-written
//   sequences cover tc_count saturation on a TC_W=2 instance and async reset
//   in the middle of a run.
// ---------------------------------------------------------------------------
module tb_down_counter_fsm;

  logic        clk = 1'b0;
  logic        rst;

  logic [15:0] load_val;
  logic        start, pause, abort, reload_en;
  logic [15:0] count;
  logic        busy, done;
  logic [7:0]  tc_count;

  logic [15:0] s_load_val;
  logic        s_start, s_pause, s_abort, s_reload_en;
  logic [15:0] s_count;
  logic        s_busy, s_done;
  logic [1:0]  s_tc_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  down_counter_fsm #(.WIDTH(16), .TC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_val  (load_val),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .reload_en (reload_en),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .tc_count  (tc_count)
  );

  down_counter_fsm #(.WIDTH(16), .TC_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .load_val  (s_load_val),
    .start     (s_start),
    .pause     (s_pause),
    .abort     (s_abort),
    .reload_en (s_reload_en),
    .count     (s_count),
    .busy      (s_busy),
    .done      (s_done),
    .tc_count  (s_tc_count)
  );

  typedef struct {
    logic        start;
    logic        pause;
    logic        abort;
    logic        reload_en;
    logic [15:0] load_val;
    logic [15:0] exp_count;
    logic        exp_busy;
    logic        exp_done;
    logic [7:0]  exp_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic pa, input logic ab, input logic re,
                     input logic [15:0] lv, input logic [15:0] ec, input logic eb,
                     input logic ed, input logic [7:0] et);
    vec_t v;
    v.start = st; v.pause = pa; v.abort = ab; v.reload_en = re; v.load_val = lv;
    v.exp_count = ec; v.exp_busy = eb; v.exp_done = ed; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    load_val = '0; start = 0; pause = 0; abort = 0; reload_en = 0;
    s_load_val = '0; s_start = 0; s_pause = 0; s_abort = 0; s_reload_en = 0;

    // ---------------- reset values ----------------
    step();
    check("rst_count", 0, int'(count), 0);
    check("rst_busy",  0, int'(busy), 0);
    check("rst_done",  0, int'(done), 0);
    check("rst_tc",    0, int'(tc_count), 0);
    check("rst_sat_tc", 0, int'(s_tc_count), 0);
    rst = 1'b0;
    step();

    // ---------------- vector table ----------------
    //  st pa ab re  lv    cnt b d tc
    // load 3: 3,2,1,0 then done, idle
    add(1, 0, 0, 0, 3,    3, 1, 0, 0);
    add(0, 0, 0, 0, 0,    2, 1, 0, 0);
    add(0, 0, 0, 0, 0,    1, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 1, 1);
    add(0, 0, 0, 0, 0,    0, 0, 0, 1);
    // load 0: one RUN cycle at 0, then done and IDLE
    add(1, 0, 0, 0, 0,    0, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 1, 1);
    add(0, 0, 0, 0, 0,    0, 0, 0, 1);
    // load 1: pause while count==0 defers the terminal event
    add(1, 0, 0, 0, 1,    1, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 1, 0, 0);
    add(0, 1, 0, 0, 0,    0, 1, 0, 0);
    add(0, 1, 0, 0, 0,    0, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 1, 1);
    add(0, 0, 0, 0, 0,    0, 0, 0, 1);
    // load 5: pause 3 cycles at count 2
    add(1, 0, 0, 0, 5,    5, 1, 0, 0);
    add(0, 0, 0, 0, 0,    4, 1, 0, 0);
    add(0, 0, 0, 0, 0,    3, 1, 0, 0);
    add(0, 0, 0, 0, 0,    2, 1, 0, 0);
    add(0, 1, 0, 0, 0,    2, 1, 0, 0);
    add(0, 1, 0, 0, 0,    2, 1, 0, 0);
    add(0, 1, 0, 0, 0,    2, 1, 0, 0);
    add(0, 0, 0, 0, 0,    1, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 1, 1);
    add(0, 0, 0, 0, 0,    0, 0, 0, 1);
    // abort beats start in IDLE: nothing changes
    add(1, 0, 1, 0, 9,    0, 0, 0, 1);
    // load 10, start in RUN ignored, abort at count 4
    add(1, 0, 0, 0, 10,   10, 1, 0, 0);
    add(0, 0, 0, 0, 0,    9, 1, 0, 0);
    add(1, 0, 0, 0, 50,   8, 1, 0, 0);
    add(0, 0, 0, 0, 0,    7, 1, 0, 0);
    add(0, 0, 0, 0, 0,    6, 1, 0, 0);
    add(0, 0, 0, 0, 0,    5, 1, 0, 0);
    add(0, 0, 0, 0, 0,    4, 1, 0, 0);
    add(0, 0, 1, 0, 0,    0, 0, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 0, 0);
    // load 2 with reload: period 3, tc 1,2,3, then stop (tc 4)
    add(1, 0, 0, 1, 2,    2, 1, 0, 0);
    add(0, 0, 0, 1, 0,    1, 1, 0, 0);
    add(0, 0, 0, 1, 0,    0, 1, 0, 0);
    add(0, 0, 0, 1, 0,    2, 1, 1, 1);
    add(0, 0, 0, 1, 0,    1, 1, 0, 1);
    add(0, 0, 0, 1, 0,    0, 1, 0, 1);
    add(0, 0, 0, 1, 0,    2, 1, 1, 2);
    add(0, 0, 0, 1, 0,    1, 1, 0, 2);
    add(0, 0, 0, 1, 0,    0, 1, 0, 2);
    add(0, 0, 0, 1, 0,    2, 1, 1, 3);
    add(0, 0, 0, 0, 0,    1, 1, 0, 3);
    add(0, 0, 0, 0, 0,    0, 1, 0, 3);
    add(0, 0, 0, 0, 0,    0, 0, 1, 4);
    add(0, 0, 0, 0, 0,    0, 0, 0, 4);

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; pause = vecs[i].pause; abort = vecs[i].abort;
      reload_en = vecs[i].reload_en; load_val = vecs[i].load_val;
      step();
      check("count",    i, int'(count),    int'(vecs[i].exp_count));
      check("busy",     i, int'(busy),     int'(vecs[i].exp_busy));
      check("done",     i, int'(done),     int'(vecs[i].exp_done));
      check("tc_count", i, int'(tc_count), int'(vecs[i].exp_tc));
      $display("vec %0d: st=%0b pa=%0b ab=%0b re=%0b lv=%0d -> count=%0d busy=%0b done=%0b tc=%0d",
               i, vecs[i].start, vecs[i].pause, vecs[i].abort, vecs[i].reload_en,
               vecs[i].load_val, count, busy, done, tc_count);
    end
    start = 0; pause = 0; abort = 0; reload_en = 0; load_val = '0;

    // ---------------- TC_W=2 saturation, reload with load 0 ----------------
    s_load_val = 16'd0; s_reload_en = 1'b1; s_start = 1'b1;
    step();
    s_start = 1'b0;
    check("sat_busy_start", 0, int'(s_busy), 1);
    check("sat_done_start", 0, int'(s_done), 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("sat_done", k, int'(s_done), 1);
      check("sat_busy", k, int'(s_busy), 1);
      check("sat_tc",   k, int'(s_tc_count), (k < 3) ? k : 3);
      $display("sat cycle %0d: count=%0d busy=%0b done=%0b tc=%0d",
               k, s_count, s_busy, s_done, s_tc_count);
    end
    s_reload_en = 1'b0;
    step();
    check("sat_stop_done", 7, int'(s_done), 1);
    check("sat_stop_busy", 7, int'(s_busy), 0);
    check("sat_stop_tc",   7, int'(s_tc_count), 3);
    step();
    check("sat_idle_done", 8, int'(s_done), 0);

    // ---------------- async reset mid-run ----------------
    // load 7 with reload: after the first terminal event count=7, done=1, tc=1
    load_val = 16'd7; reload_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check("ar_load", 0, int'(count), 7);
    for (int k = 0; k < 8; k++) step();
    check("ar_pre_count", 1, int'(count), 7);
    check("ar_pre_done",  1, int'(done), 1);
    check("ar_pre_tc",    1, int'(tc_count), 1);
    check("ar_pre_busy",  1, int'(busy), 1);
    rst = 1'b1;
    #2;  // no clock edge in between: reset must act asynchronously
    check("ar_count", 2, int'(count), 0);
    check("ar_busy",  2, int'(busy), 0);
    check("ar_done",  2, int'(done), 0);
    check("ar_tc",    2, int'(tc_count), 0);
    $display("async rst: count=%0d busy=%0b done=%0b tc=%0d", count, busy, done, tc_count);
    step();
    rst = 1'b0;
    reload_en = 1'b0;
    step();
    check("ar_after_busy", 3, int'(busy), 0);
    check("ar_after_done", 3, int'(done), 0);
    check("ar_after_count", 3, int'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
